// File: rtl/cgra_obi_arbiter.sv
// ---------------------------------------------------------------------------
// cgra_pkg + cgra_obi_arbiter
//
// Purpose:
//   Funnels the CGRA's NUM_MASTERS OBI master ports onto a single OBI master
//   port toward the system bus. Requests are arbitrated round-robin. Responses
//   are routed back in order using a small FIFO of granted master indices.
//
// Ports:
//   clk_i           clock
//   rst_i           asynchronous reset, active-high
//   masters_req_i   OBI requests from the memory nodes (one per master)
//   masters_resp_o  gnt/rvalid/rdata back to the memory nodes
//   slave_req_o     merged OBI request toward the bus
//   slave_resp_i    OBI response from the bus
//   err_o           sticky: rvalid arrived with nothing outstanding
//   gnt_cnt_o       accepted-transaction count (CGRA_ARB_PERF_EN only, else 0)
//   stall_cnt_o     cycles with a pending request but no accept
//                   (CGRA_ARB_PERF_EN only, else 0)
//
// Configuration macro:
//   CGRA_ARB_PERF_EN  enables the two 32-bit performance counters.
// ---------------------------------------------------------------------------

package cgra_pkg;
  localparam int NODES = 8;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module cgra_obi_arbiter
  import cgra_pkg::*;
#(
  parameter int NUM_MASTERS     = cgra_pkg::NODES,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  obi_req_t    masters_req_i  [NUM_MASTERS],
  output obi_resp_t   masters_resp_o [NUM_MASTERS],
  output obi_req_t    slave_req_o,
  input  obi_resp_t   slave_resp_i,
  output logic        err_o,
  output logic [31:0] gnt_cnt_o,
  output logic [31:0] stall_cnt_o
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  // Arbitration state
  logic [IDX_W-1:0] rr_ptr_reg;
  logic [IDX_W-1:0] rr_ptr_next;
  logic             lock_reg;
  logic [IDX_W-1:0] lock_idx_reg;

  // Response-order FIFO
  logic [IDX_W-1:0] fifo_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  logic             err_reg;

  logic [NUM_MASTERS-1:0] req_vec;
  logic [IDX_W-1:0]       rr_sel;
  logic [IDX_W-1:0]       sel;
  logic [IDX_W-1:0]       head_idx;
  logic                   sel_req;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   slave_req_valid;
  logic                   accept;
  logic                   pop;
  logic                   stray_rvalid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_req_vec
      assign req_vec[gi] = masters_req_i[gi].req;
    end
  endgenerate

  // Round-robin search: first requester at or above rr_ptr, wrapping.
  always_comb begin
    logic [IDX_W:0] cand;
    logic           found;
    rr_sel = rr_ptr_reg;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = {1'b0, rr_ptr_reg} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_MASTERS)) begin
        cand = cand - (IDX_W+1)'(NUM_MASTERS);
      end
      if (!found && req_vec[cand[IDX_W-1:0]]) begin
        found  = 1'b1;
        rr_sel = cand[IDX_W-1:0];
      end
    end
  end

  // While locked, only the locked master may be forwarded; if it drops its
  // request the bus request is withdrawn so nothing is pushed, and the lock
  // falls away at the next edge.
  assign sel      = lock_reg ? lock_idx_reg : rr_sel;
  assign sel_req  = lock_reg ? req_vec[lock_idx_reg] : (|req_vec);

  // Full is judged on the registered count, so a same-cycle pop never
  // frees a slot for a same-cycle push.
  assign fifo_full  = (count_reg == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count_reg == '0);

  assign slave_req_valid = sel_req & ~fifo_full & ~rst_i;
  assign accept          = slave_req_valid & slave_resp_i.gnt;
  assign pop             = slave_resp_i.rvalid & ~fifo_empty & ~rst_i;
  assign stray_rvalid    = slave_resp_i.rvalid & fifo_empty;
  assign head_idx        = fifo_mem[rd_ptr_reg];

  assign rr_ptr_next = (sel == IDX_W'(NUM_MASTERS - 1)) ? '0 : sel + IDX_W'(1);

  always_comb begin
    count_next = count_reg;
    case ({accept, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    slave_req_o     = masters_req_i[sel];
    slave_req_o.req = slave_req_valid;
  end

  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_resp
      assign masters_resp_o[gi].gnt    = accept && (sel == IDX_W'(gi));
      assign masters_resp_o[gi].rvalid = pop && (head_idx == IDX_W'(gi));
      assign masters_resp_o[gi].rdata  = slave_resp_i.rdata;
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_reg   <= '0;
      lock_reg     <= 1'b0;
      lock_idx_reg <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      err_reg      <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (accept) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        rr_ptr_reg <= rr_ptr_next;
        lock_reg   <= 1'b0;
      end else if (slave_req_valid) begin
        // Request visible on the bus but not granted: hold the selection.
        lock_reg     <= 1'b1;
        lock_idx_reg <= sel;
      end else begin
        lock_reg <= 1'b0;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (stray_rvalid) begin
        err_reg <= 1'b1;
      end
    end
  end

  // Index storage carries no reset; validity is tracked by count_reg.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      fifo_mem[wr_ptr_reg] <= sel;
    end
  end

  assign err_o = err_reg;

`ifdef CGRA_ARB_PERF_EN
  logic [31:0] gnt_cnt_reg;
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_cnt_reg   <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (accept) begin
        gnt_cnt_reg <= gnt_cnt_reg + 32'd1;
      end
      if ((|req_vec) && !accept) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
    end
  end

  assign gnt_cnt_o   = gnt_cnt_reg;
  assign stall_cnt_o = stall_cnt_reg;
`else
  assign gnt_cnt_o   = '0;
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cgra_obi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cgra_obi_arbiter
//
// Directed self-checking bench for cgra_obi_arbiter (8 masters, 4 outstanding).
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// 2 time units after the edge, well away from the next active edge.
// ---------------------------------------------------------------------------

module tb_cgra_obi_arbiter;
  import cgra_pkg::*;

  localparam int N = 8;

  logic        clk;
  logic        rst;
  obi_req_t    m_req  [N];
  obi_resp_t   m_resp [N];
  obi_req_t    s_req;
  obi_resp_t   s_resp;
  logic        err;
  logic [31:0] gnt_cnt;
  logic [31:0] stall_cnt;

  logic [N-1:0] gnt_vec;
  logic [N-1:0] rvalid_vec;

  int total;
  int bad;

  cgra_obi_arbiter #(
    .NUM_MASTERS     (N),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .masters_req_i  (m_req),
    .masters_resp_o (m_resp),
    .slave_req_o    (s_req),
    .slave_resp_i   (s_resp),
    .err_o          (err),
    .gnt_cnt_o      (gnt_cnt),
    .stall_cnt_o    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    gnt_vec    = '0;
    rvalid_vec = '0;
    for (int i = 0; i < N; i++) begin
      gnt_vec[i]    = m_resp[i].gnt;
      rvalid_vec[i] = m_resp[i].rvalid;
    end
  end

  // One line per bus transaction (accept or response).
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (m_resp[i].gnt)
        $display("accept   master=%0d addr=%08h", i, s_req.addr);
      if (m_resp[i].rvalid)
        $display("response master=%0d rdata=%08h", i, m_resp[i].rdata);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int m, input logic r, input logic [31:0] a);
    m_req[m].req   = r;
    m_req[m].addr  = a;
    m_req[m].we    = 1'b0;
    m_req[m].be    = 4'hF;
    m_req[m].wdata = 32'h0;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h0);
  endtask

  task automatic bus(input logic g, input logic rv, input logic [31:0] rd);
    s_resp.gnt    = g;
    s_resp.rvalid = rv;
    s_resp.rdata  = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int order [6];
    order = '{0, 2, 5, 0, 2, 5};
    total = 0;
    bad   = 0;

    // ---------------- reset state ----------------
    rst = 1'b1;
    clear_reqs();
    bus(1'b1, 1'b0, 32'h0);
    set_req(0, 1'b1, 32'h10);
    settle();
    check_val("rst_slave_req", 32'(s_req.req), 32'd0);
    check_val("rst_gnt", 32'(gnt_vec), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    step();
    step();
    rst = 1'b0;
    clear_reqs();
    bus(1'b0, 1'b0, 32'h0);

    // ---------------- round robin 0,2,5 with 1-cycle rvalid ----------------
    for (int k = 0; k <= 6; k++) begin
      step();
      if (k == 0) begin
        set_req(0, 1'b1, 32'h00);
        set_req(2, 1'b1, 32'h20);
        set_req(5, 1'b1, 32'h50);
      end
      if (k == 6) clear_reqs();
      if (k > 0) bus(k < 6, 1'b1, 32'hA000_0000 + 32'(order[k-1] * 16));
      else       bus(1'b1, 1'b0, 32'h0);
      settle();
      if (k < 6) begin
        check_val($sformatf("rr_gnt_%0d", k), 32'(gnt_vec), 32'd1 << order[k]);
        check_val($sformatf("rr_addr_%0d", k), s_req.addr, 32'(order[k] * 16));
      end
      if (k > 0) begin
        check_val($sformatf("rr_rvalid_%0d", k), 32'(rvalid_vec), 32'd1 << order[k-1]);
        check_val($sformatf("rr_rdata_%0d", k), m_resp[order[k-1]].rdata,
                  32'hA000_0000 + 32'(order[k-1] * 16));
      end
    end

    // ---------------- lock: gnt held low, newcomer waits ----------------
    step();
    bus(1'b0, 1'b0, 32'h0);
    set_req(3, 1'b1, 32'h100);
    settle();
    check_val("lock_addr_0", s_req.addr, 32'h100);
    check_val("lock_req_0", 32'(s_req.req), 32'd1);
    check_val("lock_gnt_0", 32'(gnt_vec), 32'd0);
    step();
    set_req(1, 1'b1, 32'h104);
    settle();
    check_val("lock_addr_1", s_req.addr, 32'h100);
    step();
    settle();
    check_val("lock_addr_2", s_req.addr, 32'h100);
    check_val("lock_req_2", 32'(s_req.req), 32'd1);
    step();
    bus(1'b1, 1'b0, 32'h0);
    settle();
    check_val("lock_gnt_m3", 32'(gnt_vec), 32'd1 << 3);
    check_val("lock_addr_3", s_req.addr, 32'h100);
    step();
    set_req(3, 1'b0, 32'h0);
    settle();
    check_val("lock_gnt_m1", 32'(gnt_vec), 32'd1 << 1);
    check_val("lock_addr_m1", s_req.addr, 32'h104);
    step();
    clear_reqs();
    bus(1'b0, 1'b1, 32'h55);
    settle();
    check_val("lock_rv_m3", 32'(rvalid_vec), 32'd1 << 3);
    step();
    bus(1'b0, 1'b1, 32'h66);
    settle();
    check_val("lock_rv_m1", 32'(rvalid_vec), 32'd1 << 1);

    // ---------------- FIFO full, single requester ----------------
    step();
    bus(1'b1, 1'b0, 32'h0);
    set_req(6, 1'b1, 32'h600);
    settle();
    check_val("full_gnt_0", 32'(gnt_vec), 32'd1 << 6);
    for (int i = 1; i < 4; i++) begin
      step();
      settle();
      check_val($sformatf("full_gnt_%0d", i), 32'(gnt_vec), 32'd1 << 6);
    end
    step();
    settle();
    check_val("full_req_off", 32'(s_req.req), 32'd0);
    check_val("full_gnt_off", 32'(gnt_vec), 32'd0);
    step();
    bus(1'b1, 1'b1, 32'h77);
    settle();
    check_val("full_pop_req_off", 32'(s_req.req), 32'd0);
    check_val("full_pop_rv", 32'(rvalid_vec), 32'd1 << 6);
    step();
    bus(1'b1, 1'b0, 32'h0);
    settle();
    check_val("full_fifth_gnt", 32'(gnt_vec), 32'd1 << 6);
    step();
    clear_reqs();
    bus(1'b0, 1'b1, 32'h78);
    settle();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        step();
        settle();
      end
      check_val($sformatf("full_drain_%0d", i), 32'(rvalid_vec), 32'd1 << 6);
    end

    // ---------------- routing for 4,1,7 ----------------
    step();
    bus(1'b1, 1'b0, 32'h0);
    set_req(4, 1'b1, 32'h400);
    settle();
    check_val("ooo_gnt_4", 32'(gnt_vec), 32'd1 << 4);
    step();
    set_req(4, 1'b0, 32'h0);
    set_req(1, 1'b1, 32'h410);
    settle();
    check_val("ooo_gnt_1", 32'(gnt_vec), 32'd1 << 1);
    step();
    set_req(1, 1'b0, 32'h0);
    set_req(7, 1'b1, 32'h470);
    settle();
    check_val("ooo_gnt_7", 32'(gnt_vec), 32'd1 << 7);
    step();
    clear_reqs();
    bus(1'b0, 1'b1, 32'h11);
    settle();
    check_val("ooo_rv_4", 32'(rvalid_vec), 32'd1 << 4);
    check_val("ooo_rdata_4", m_resp[4].rdata, 32'h11);
    check_val("ooo_bcast_0", m_resp[0].rdata, 32'h11);
    step();
    bus(1'b0, 1'b1, 32'h22);
    settle();
    check_val("ooo_rv_1", 32'(rvalid_vec), 32'd1 << 1);
    check_val("ooo_rdata_1", m_resp[1].rdata, 32'h22);
    step();
    bus(1'b0, 1'b1, 32'h33);
    settle();
    check_val("ooo_rv_7", 32'(rvalid_vec), 32'd1 << 7);
    check_val("ooo_rdata_7", m_resp[7].rdata, 32'h33);

    // ---------------- stray rvalid -> sticky err ----------------
    step();
    bus(1'b0, 1'b1, 32'h99);
    settle();
    check_val("stray_rv_none", 32'(rvalid_vec), 32'd0);
    check_val("stray_err_before", 32'(err), 32'd0);
    step();
    bus(1'b0, 1'b0, 32'h0);
    settle();
    check_val("stray_err_set", 32'(err), 32'd1);
    step();
    step();
    settle();
    check_val("stray_err_sticky", 32'(err), 32'd1);

    // ---------------- reset mid-operation ----------------
    step();
    set_req(0, 1'b1, 32'h0);
    bus(1'b1, 1'b0, 32'h0);
    settle();
    check_val("mid_gnt_0", 32'(gnt_vec), 32'd1 << 0);
    step();
    clear_reqs();
    bus(1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    settle();
    check_val("mid_rst_err", 32'(err), 32'd0);
    check_val("mid_rst_req", 32'(s_req.req), 32'd0);
    step();
    step();
    rst = 1'b0;
    bus(1'b0, 1'b1, 32'hAB);
    settle();
    check_val("mid_discard_rv", 32'(rvalid_vec), 32'd0);
    step();
    bus(1'b1, 1'b0, 32'h0);
    set_req(0, 1'b1, 32'h0);
    set_req(3, 1'b1, 32'h30);
    settle();
    check_val("mid_err_again", 32'(err), 32'd1);
    check_val("mid_rrptr_zero", 32'(gnt_vec), 32'd1 << 0);

    // ---------------- performance counters ----------------
    step();
    clear_reqs();
    bus(1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    set_req(1, 1'b1, 32'h10);
    bus(1'b1, 1'b0, 32'h0);
    settle();
    check_val("perf_gnt_rst", gnt_cnt, 32'd0);
    check_val("perf_stall_rst", stall_cnt, 32'd0);
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c <= 9)       bus(1'b1, 1'b1, 32'h1);
      else if (c == 10) bus(1'b0, 1'b1, 32'h1);
      else              bus(1'b0, 1'b0, 32'h0);
      if (c == 16) clear_reqs();
    end
    settle();
`ifdef CGRA_ARB_PERF_EN
    check_val("perf_gnt_cnt", gnt_cnt, 32'd10);
    check_val("perf_stall_cnt", stall_cnt, 32'd6);
`else
    check_val("perf_gnt_cnt", gnt_cnt, 32'd0);
    check_val("perf_stall_cnt", stall_cnt, 32'd0);
`endif
    check_val("perf_err_clear", 32'(err), 32'd0);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
